mem_arbiter: RTL

Shares a single memory port between the CPU instruction-fetch channel and the CPU data (load/store) channel. It uses the same valid/ack request and response handshakes as the processor. It latches the granted request, forwards it to memory, and routes the read response back to its owner. Only one transaction is outstanding at a time. The block sits between mips_cpu and the unified memory/bus interface.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_arb_pick2.sv | 28 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ===================================================================
// mem_arbiter_pkg : shared encodings for the CPU memory-port arbiter
// Revision        : 1.0
// ===================================================================
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_RESP = 3'b100
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_arb_pick2.sv
`default_nettype none
// ===================================================================
// arb_pick2 : two-way fetch/data picker, fixed data priority or
//             round-robin on ties
// Revision  : 1.0
// ===================================================================
module arb_pick2
  import mem_arbiter_pkg::*;
(
  input  logic   req_inst,
  input  logic   req_data,
  input  owner_t last_grant,
  input  logic   priority_mode,
  output logic   grant_data
);

  always_comb begin
    grant_data = 1'b0;
    if (req_data && !req_inst) begin
      grant_data = 1'b1;
    end else if (req_data && req_inst) begin
      // On a tie without fixed priority, the side not served last wins.
      grant_data = priority_mode || (last_grant == OWN_INST);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ===================================================================
// mem_arbiter : shares one memory port between CPU fetch and data
//               channels, one outstanding transaction at a time
// Revision    : 1.0
// ===================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_PRIORITY = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_addr,
  input  logic             inst_req_valid,
  output logic             inst_req_ack,
  output logic [31:0]      inst_rdata,
  output logic             inst_rvalid,
  input  logic             inst_rack,
  input  logic [31:0]      data_addr,
  input  logic             data_wen,
  input  logic             data_ren,
  input  logic [31:0]      data_wdata,
  input  logic [3:0]       data_wstrb,
  output logic             data_req_ack,
  output logic [31:0]      data_rdata,
  output logic             data_rvalid,
  input  logic             data_rack,
  output logic [31:0]      mem_addr,
  output logic             mem_wen,
  output logic             mem_ren,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_req_ack,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic             mem_rack,
  output logic [CNT_W-1:0] conflict_cnt
);

  state_t r_state;
  state_t w_state_nxt;
  owner_t r_owner;
  owner_t r_last_grant;

  logic w_inst_pend;
  logic w_data_pend;
  logic w_grant_data;
  logic w_owner_rack;

  assign w_inst_pend  = inst_req_valid;
  assign w_data_pend  = data_wen | data_ren;
  assign w_owner_rack = (r_owner == OWN_DATA) ? data_rack : inst_rack;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  arb_pick2 u_pick (
    .req_inst      (w_inst_pend),
    .req_data      (w_data_pend),
    .last_grant    (r_last_grant),
    .priority_mode (DATA_PRIORITY != 0),
    .grant_data    (w_grant_data)
  );

  always_comb begin
    w_state_nxt  = r_state;
    inst_req_ack = 1'b0;
    data_req_ack = 1'b0;
    inst_rvalid  = 1'b0;
    data_rvalid  = 1'b0;
    mem_rack     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_inst_pend || w_data_pend) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (r_owner == OWN_DATA) data_req_ack = mem_req_ack;
        else                     inst_req_ack = mem_req_ack;
        // Writes have no response phase.
        if (mem_req_ack) w_state_nxt = mem_wen ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        if (r_owner == OWN_DATA) data_rvalid = mem_rvalid;
        else                     inst_rvalid = mem_rvalid;
        mem_rack = w_owner_rack;
        if (mem_rvalid && w_owner_rack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_INST;
      r_last_grant <= OWN_INST;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      mem_wstrb    <= 4'h0;
      mem_wen      <= 1'b0;
      mem_ren      <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_inst_pend && w_data_pend) conflict_cnt <= conflict_cnt + CNT_W'(1);
          if (w_inst_pend || w_data_pend) begin
            r_owner      <= w_grant_data ? OWN_DATA : OWN_INST;
            r_last_grant <= w_grant_data ? OWN_DATA : OWN_INST;
            if (w_grant_data) begin
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
              mem_wstrb <= data_wstrb;
              mem_wen   <= data_wen;
              mem_ren   <= data_ren & ~data_wen;
            end else begin
              mem_addr  <= inst_addr;
              mem_wdata <= 32'h0;
              mem_wstrb <= 4'h0;
              mem_wen   <= 1'b0;
              mem_ren   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ack) begin
            mem_wen <= 1'b0;
            mem_ren <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
